// File: rtl/operand_sequencer.sv
// Operand sequencer for an external ripple adder.
// Strobes in A and B, holds them for the settle time, then captures the sum and flags.
module operand_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_stb,
  input  logic             chain,
  input  logic             cin,
  input  logic             start,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [7:0]       op_count
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    GOT_A,
    READY,
    SETTLE
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  assign zero = (result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_ci    <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_count  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_stb) begin
            add_a <= chain ? result : din;
            state <= GOT_A;
          end
        end
        GOT_A: begin
          if (load_stb) begin
            add_b  <= din;
            add_ci <= cin;
            state  <= READY;
          end
        end
        READY: begin
          // start takes priority; a late load_stb never disturbs held operands
          if (start) begin
            cnt   <= 4'(SETTLE_CYCLES - 1);
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            result    <= add_s;
            carry_out <= add_co;
            ovf       <= (add_a[MSB] == add_b[MSB]) &&
                         (add_s[MSB] != add_a[MSB]);
            op_count  <= op_count + 8'd1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a behavioural ripple adder.
// A second instance built with a one-cycle settle checks the short latency.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       load_stb, chain, cin, start;
  logic [7:0] add_a, add_b, add_s, result, op_count;
  logic       add_ci, add_co, carry_out, ovf, zero, busy, done;

  logic       load_stb1, start1;
  logic [7:0] add_a1, add_b1, add_s1, result1, op_count1;
  logic       add_ci1, add_co1, carry_out1, ovf1, zero1, busy1, done1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign {add_co, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};
  assign {add_co1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'd0, add_ci1};

  operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load_stb(load_stb),
    .chain(chain), .cin(cin), .start(start),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .result(result), .carry_out(carry_out), .ovf(ovf), .zero(zero),
    .busy(busy), .done(done), .op_count(op_count)
  );

  operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .load_stb(load_stb1),
    .chain(chain), .cin(cin), .start(start1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
    .add_s(add_s1), .add_co(add_co1),
    .result(result1), .carry_out(carry_out1), .ovf(ovf1), .zero(zero1),
    .busy(busy1), .done(done1), .op_count(op_count1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stb_a(input logic [7:0] v, input logic ch);
    din = v; chain = ch; load_stb = 1'b1;
    tick();
    load_stb = 1'b0; chain = 1'b0;
  endtask

  task automatic stb_b(input logic [7:0] v, input logic ci);
    din = v; cin = ci; load_stb = 1'b1;
    tick();
    load_stb = 1'b0; cin = 1'b0;
  endtask

  // start at edge k, capture at edge k+4, done only in the cycle after
  task automatic go(input bit timed);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (timed) chk("busy_k", {31'd0, busy}, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      if (timed) begin
        chk("busy_settle", {31'd0, busy}, 1);
        chk("done_early", {31'd0, done}, 0);
      end
    end
    tick();
    if (timed) begin
      chk("done_pulse", {31'd0, done}, 1);
      chk("busy_end", {31'd0, busy}, 0);
    end
    tick();
    if (timed) chk("done_off", {31'd0, done}, 0);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input logic ci, input bit timed);
    stb_a(a, 1'b0);
    stb_b(b, ci);
    go(timed);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; load_stb = 0; chain = 0; cin = 0; start = 0;
    load_stb1 = 0; start1 = 0;
    #12;
    chk("rst_add_a", {24'd0, add_a}, 0);
    chk("rst_add_b", {24'd0, add_b}, 0);
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_zero", {31'd0, zero}, 1);
    chk("rst_busy_done", {30'd0, busy, done}, 0);
    chk("rst_op_count", {24'd0, op_count}, 0);
    rst_n = 1'b1;
    tick();

    op(8'h12, 8'h34, 1'b0, 1'b1);
    chk("basic_result", {24'd0, result}, 32'h46);
    chk("basic_flags", {29'd0, carry_out, ovf, zero}, 0);
    chk("basic_count", {24'd0, op_count}, 1);

    stb_a(8'h99, 1'b1);
    chk("chain_add_a", {24'd0, add_a}, 32'h46);
    stb_b(8'h10, 1'b0);
    go(1'b0);
    chk("chain_result", {24'd0, result}, 32'h56);

    op(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("carry_result", {24'd0, result}, 0);
    chk("carry_flags", {29'd0, carry_out, ovf, zero}, 32'b101);

    op(8'h7F, 8'h00, 1'b1, 1'b0);
    chk("ovf_result", {24'd0, result}, 32'h80);
    chk("ovf_flags", {29'd0, carry_out, ovf, zero}, 32'b010);
    chk("ovf_count", {24'd0, op_count}, 4);

    start = 1'b1; tick(); start = 1'b0;
    chk("start_idle_busy", {31'd0, busy}, 0);
    stb_a(8'h05, 1'b0);
    chk("idle_kept_a", {24'd0, add_a}, 32'h05);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_gota_busy", {31'd0, busy}, 0);
    stb_b(8'h03, 1'b0);
    chk("gota_kept_b", {24'd0, add_b}, 32'h03);
    stb_b(8'hAA, 1'b1);
    chk("ready_load_b", {24'd0, add_b}, 32'h03);
    chk("ready_load_ci", {31'd0, add_ci}, 0);
    din = 8'hBB; load_stb = 1'b1; start = 1'b1;
    tick();
    load_stb = 1'b0; start = 1'b0;
    chk("both_busy", {31'd0, busy}, 1);
    chk("both_add_b", {24'd0, add_b}, 32'h03);
    repeat (4) tick();
    chk("both_result", {24'd0, result}, 32'h08);
    chk("both_count", {24'd0, op_count}, 5);

    din = 8'h21; load_stb = 1'b1;
    tick(); tick();
    load_stb = 1'b0;
    chk("held_a", {24'd0, add_a}, 32'h21);
    chk("held_b", {24'd0, add_b}, 32'h21);
    go(1'b0);
    chk("held_result", {24'd0, result}, 32'h42);

    stb_a(8'h10, 1'b0);
    stb_b(8'h20, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_result", {24'd0, result}, 0);
    chk("abort_operands", {15'd0, add_a, add_b, add_ci}, 0);
    chk("abort_count", {24'd0, op_count}, 0);
    chk("abort_zero", {31'd0, zero}, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", {31'd0, done}, 0);
    end
    op(8'h01, 8'h02, 1'b0, 1'b1);
    chk("recover_result", {24'd0, result}, 32'h03);
    chk("recover_count", {24'd0, op_count}, 1);

    for (int i = 0; i < 254; i++) op(8'(i), 8'h01, 1'b0, 1'b0);
    chk("count_255", {24'd0, op_count}, 255);
    chk("loop_result", {24'd0, result}, 32'hFE);
    op(8'h00, 8'h00, 1'b0, 1'b0);
    chk("count_wrap", {24'd0, op_count}, 0);
    chk("wrap_zero", {31'd0, zero}, 1);

    din = 8'h40; load_stb1 = 1'b1;
    tick(); tick();
    load_stb1 = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("s1_busy", {31'd0, busy1}, 1);
    chk("s1_done_early", {31'd0, done1}, 0);
    tick();
    chk("s1_done", {31'd0, done1}, 1);
    chk("s1_busy_end", {31'd0, busy1}, 0);
    chk("s1_result", {24'd0, result1}, 32'h80);
    chk("s1_ovf", {31'd0, ovf1}, 1);
    tick();
    chk("s1_done_off", {31'd0, done1}, 0);
    chk("s1_count", {24'd0, op_count1}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
